// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and default geometry for the cache-line <-> memory burst adaptor.
package cacheline_adaptor_pkg;

    localparam int LINE_W_DEF  = 256;
    localparam int BURST_W_DEF = 64;
    localparam int BEATS       = LINE_W_DEF / BURST_W_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } cla_state_e;

endpackage

// File: rtl/cla_watchdog.sv
// Stall watchdog: counts busy cycles without a memory response and flags
// expiry on the LIMIT-th consecutive silent cycle.
module cla_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic kick,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Idle cycles hold the counter at zero, so every RD/WR entry starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!active || kick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign expired = active && !kick && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/cacheline_adaptor.sv
// Moves one cache line to/from memory as LINE_W/BURST_W bursts, LSB beat first.
// Define CACHELINE_ADAPTOR_TIMEOUT_EN to add the stall watchdog and sticky err_o.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int LINE_W         = LINE_W_DEF,
    parameter int BURST_W        = BURST_W_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    // cache side
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               resp_o,
    // memory side
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    output logic [BURST_W-1:0] burst_o,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               resp_i,
    // debug: current FSM state (cla_state_e encoding)
    output logic [1:0]         state_o
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    ,
    output logic               err_o
`endif
);

    localparam int NBEATS = LINE_W / BURST_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBEATS - 1);

    if (LINE_W != NBEATS * BURST_W || NBEATS < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("cacheline_adaptor: unsupported LINE_W/BURST_W/TIMEOUT_CYCLES");
    end

    cla_state_e          state;
    logic [CNT_W-1:0]    cnt;
    logic [LINE_W-1:0]   wr_line;
    logic                busy;
    logic                last_beat;
    logic                finish;
    logic                wd_expired;

    assign busy      = (state == RD) || (state == WR);
    assign last_beat = busy && resp_i && (cnt == LAST);
    assign finish    = busy && (wd_expired || last_beat);
    assign state_o   = state;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    cla_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (busy),
        .kick    (resp_i),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_line   <= '0;
            line_o    <= '0;
            resp_o    <= 1'b0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            burst_o   <= '0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
            err_o     <= 1'b0;
`endif
        end else begin
            // Read beats land directly in line_o, which otherwise holds the last line read.
            if (state == RD && resp_i && !wd_expired) begin
                line_o[int'(cnt) * BURST_W +: BURST_W] <= burst_i;
            end
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
            if (wd_expired) begin
                err_o <= 1'b1;
            end
`endif
            if (finish) begin
                state     <= DONE;
                cnt       <= '0;
                read_o    <= 1'b0;
                write_o   <= 1'b0;
                address_o <= '0;
                burst_o   <= '0;
                resp_o    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (write_i) begin
                            state     <= WR;
                            cnt       <= '0;
                            wr_line   <= line_i;
                            address_o <= {address_i[31:5], 5'b0};
                            write_o   <= 1'b1;
                            burst_o   <= line_i[BURST_W-1:0];
                        end else if (read_i) begin
                            state     <= RD;
                            cnt       <= '0;
                            address_o <= {address_i[31:5], 5'b0};
                            read_o    <= 1'b1;
                        end
                    end
                    RD: begin
                        if (resp_i) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WR: begin
                        // burst_o is registered, so present the next beat as this one is taken.
                        if (resp_i) begin
                            cnt     <= cnt + 1'b1;
                            burst_o <= wr_line[(int'(cnt) + 1) * BURST_W +: BURST_W];
                        end
                    end
                    DONE: begin
                        resp_o <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: randomized line reads/writes against a
// line-level memory model, with directed latency, reset-abort and arbitration cases.
module tb_cacheline_adaptor;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int BEATS   = cacheline_adaptor_pkg::BEATS;

    typedef struct packed {
        logic              is_read;
        logic              chk_line;
        logic [LINE_W-1:0] line;
    } resp_t;

    logic               clk;
    logic               rst_n;
    logic [31:0]        address_i;
    logic               read_i;
    logic               write_i;
    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic               resp_o;
    logic [31:0]        address_o;
    logic               read_o;
    logic               write_o;
    logic [BURST_W-1:0] burst_o;
    logic [BURST_W-1:0] burst_i;
    logic               resp_i;
    logic [1:0]         state_o;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    logic               err_o;
`endif

    cacheline_adaptor #(
        .LINE_W         (LINE_W),
        .BURST_W        (BURST_W),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i),
        .state_o   (state_o)
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        ,
        .err_o     (err_o)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard state ----------------
    resp_t              exp_resp_q[$];
    logic [BURST_W-1:0] exp_burst_q[$];
    logic [BURST_W-1:0] rd_data_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0]       exp_addr = '0;
    logic              cur_rd = 1'b0;
    logic              cur_wr = 1'b0;
    logic [LINE_W-1:0] held = '0;
    logic              line_chk_en = 1'b1;
    logic              prev_resp = 1'b0;
    logic              expect_timeout = 1'b0;
    logic [31:0]       seen_addr = '0;
    int                done_cnt = 0;
    int                target = 0;
    int                issue_cyc = 0;
    int                resp_cyc = 0;
    int                rd_beats = 0;
    int                rd_cycles = 0;
    int                mode = 1;     // 0 random, 1 always, 2 never, 3 every other cycle
    logic              alt = 1'b0;

    task automatic check(input string name, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- memory responder ----------------
    always @(negedge clk) begin
        logic r;
        case (mode)
            0:       r = ($urandom_range(0, 3) != 0);
            1:       r = 1'b1;
            2:       r = 1'b0;
            default: begin alt = !alt; r = alt; end
        endcase
        resp_i = r;
        if (read_o && r && rd_data_q.size() > 0) burst_i = rd_data_q.pop_front();
        else burst_i = {$urandom, $urandom};
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        resp_t e;
        #1;
        if (read_o || write_o) begin
            check("req_kind", LINE_W'({read_o, write_o}), LINE_W'({cur_rd, cur_wr}));
            check("address_o", LINE_W'(address_o), LINE_W'(exp_addr));
            seen_addr = address_o;
            if (read_o) rd_cycles++;
        end else begin
            check("address_idle", LINE_W'(address_o), '0);
            check("burst_idle", LINE_W'(burst_o), '0);
        end
        if (write_o && resp_i) begin
            if (exp_burst_q.size() == 0) fail("burst_extra");
            else check("burst_o", LINE_W'(burst_o), LINE_W'(exp_burst_q.pop_front()));
        end
        if (read_o && resp_i) rd_beats++;
        if (resp_o) begin
            check("resp_single", LINE_W'(prev_resp), '0);
            if (exp_resp_q.size() == 0) begin
                fail("resp_unexpected");
            end else begin
                e = exp_resp_q.pop_front();
                if (e.is_read && e.chk_line) begin
                    check("line_o", line_o, e.line);
                    held = e.line;
                    line_chk_en = 1'b1;
                end else if (e.is_read) begin
                    line_chk_en = 1'b0;
                end
                resp_cyc = cyc;
                done_cnt++;
            end
        end
        if (!read_o && line_chk_en) check("line_hold", line_o, held);
        prev_resp = resp_o;
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic wr, input logic rd, input logic [31:0] addr, input logic [LINE_W-1:0] line);
        resp_t e;
        @(negedge clk);
        address_i = addr;
        line_i    = line;
        write_i   = wr;
        read_i    = rd;
        exp_addr  = addr & 32'hffff_ffe0;
        cur_wr    = wr;
        cur_rd    = rd && !wr;
        rd_beats  = 0;
        rd_cycles = 0;
        issue_cyc = cyc;
        e.is_read  = !wr;
        e.chk_line = !expect_timeout;
        e.line     = line;
        for (int i = 0; i < BEATS; i++) begin
            if (wr) exp_burst_q.push_back(line[i*BURST_W +: BURST_W]);
            else if (!expect_timeout) rd_data_q.push_back(line[i*BURST_W +: BURST_W]);
        end
        exp_resp_q.push_back(e);
        target = done_cnt + 1;
        @(negedge clk);
        write_i = 1'b0;
        read_i  = 1'b0;
    endtask

    task automatic wait_done(input logic junk, input int budget);
        int n = 0;
        @(negedge clk);
        while (done_cnt < target && n < budget) begin
            if (junk) begin
                read_i    = 1'($urandom_range(0, 1));
                write_i   = 1'($urandom_range(0, 1));
                address_i = $urandom;
                line_i    = rand_line();
            end
            n++;
            @(negedge clk);
        end
        if (done_cnt < target) fail("done_timeout");
        read_i  = 1'b0;
        write_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [LINE_W-1:0] l;
        int op;
        int n;
        rst_n = 1'b0; address_i = '0; read_i = 1'b0; write_i = 1'b0; line_i = '0;
        repeat (3) @(negedge clk);
        check("rst_state", LINE_W'(state_o), '0);
        check("rst_read_o", LINE_W'(read_o), '0);
        check("rst_write_o", LINE_W'(write_o), '0);
        check("rst_resp_o", LINE_W'(resp_o), '0);
        check("rst_line_o", line_o, '0);
        rst_n = 1'b1;

        // directed read: fixed bursts, resp_i every cycle
        mode = 1;
        l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        issue(1'b0, 1'b1, 32'h1234_5678, l);
        wait_done(1'b0, 50);
        check("rd_latency", LINE_W'(resp_cyc - issue_cyc + 1), LINE_W'(6));
        check("rd_addr_aligned", LINE_W'(seen_addr), LINE_W'(32'h1234_5660));

        // directed write with a one-cycle gap between beats
        mode = 3;
        issue(1'b1, 1'b0, 32'hdead_beef,
              256'h0123456789abcdef_1032547698badcfe_89abcdef01234567_fedcba9876543210);
        wait_done(1'b0, 100);

        // read and write together: write wins
        mode = 0;
        issue(1'b1, 1'b1, 32'h0000_0040, rand_line());
        wait_done(1'b1, 200);

        // randomized mix
        for (int t = 0; t < 30; t++) begin
            op   = $urandom_range(0, 2);
            mode = (t % 4 == 0) ? 1 : ((t % 4 == 1) ? 3 : 0);
            issue(op != 0, op != 1, $urandom, rand_line());
            wait_done(1'b1, 300);
            if (mode == 1) check("latency", LINE_W'(resp_cyc - issue_cyc + 1), LINE_W'(6));
        end

        // reset after the second read beat abandons the transfer
        mode = 1;
        issue(1'b0, 1'b1, 32'hcafe_0000, rand_line());
        n = 0;
        while (rd_beats < 2 && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (rd_beats < 2) fail("beat2_timeout");
        #2;
        rst_n = 1'b0;
        held = '0;
        line_chk_en = 1'b1;
        #1;
        check("abort_read_o", LINE_W'(read_o), '0);
        check("abort_write_o", LINE_W'(write_o), '0);
        check("abort_resp_o", LINE_W'(resp_o), '0);
        check("abort_address_o", LINE_W'(address_o), '0);
        check("abort_burst_o", LINE_W'(burst_o), '0);
        check("abort_line_o", line_o, '0);
        rd_data_q.delete();
        void'(exp_resp_q.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        issue(1'b0, 1'b1, 32'h8000_1234, rand_line());
        wait_done(1'b0, 50);
        check("post_reset_latency", LINE_W'(resp_cyc - issue_cyc + 1), LINE_W'(6));

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        // memory never answers: watchdog forces completion and latches err_o
        mode = 2;
        check("err_clear", LINE_W'(err_o), '0);
        expect_timeout = 1'b1;
        issue(1'b0, 1'b1, 32'h0000_1000, rand_line());
        wait_done(1'b0, 100);
        expect_timeout = 1'b0;
        check("err_set", LINE_W'(err_o), LINE_W'(1));
        check("timeout_rd_cycles", LINE_W'(rd_cycles), LINE_W'(16));
        repeat (5) @(negedge clk);
        check("err_sticky", LINE_W'(err_o), LINE_W'(1));
        rst_n = 1'b0;
        held = '0;
        line_chk_en = 1'b1;
        #1;
        check("err_reset", LINE_W'(err_o), '0);
        @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
`endif

        repeat (5) @(negedge clk);
        check("resp_q_empty", LINE_W'(exp_resp_q.size()), '0);
        check("burst_q_empty", LINE_W'(exp_burst_q.size()), '0);
        check("rd_data_q_empty", LINE_W'(rd_data_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
